// File: rtl/alu_sel_ctx_seq.sv
// Context sequencer for a PE operand-select mux: on START it steps a small context table,
// presenting each entry for RPT+1 cycles. Define ALU_SEL_CTX_LOOP_EN for wrap-around with STOP.
module alu_sel_ctx_seq #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 16,
  parameter int RPT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [SEL_W-1:0]  WR_SEL_A,
  input  logic [SEL_W-1:0]  WR_SEL_B,
  input  logic [DATA_W-1:0] WR_CONST_A,
  input  logic [DATA_W-1:0] WR_CONST_B,
  input  logic [RPT_W-1:0]  WR_RPT,
  output logic              WR_ERR,
  input  logic [AW:0]       NUM_CTX,
  input  logic              START,
  input  logic              STALL,
`ifdef ALU_SEL_CTX_LOOP_EN
  input  logic              STOP,
`endif
  output logic [SEL_W-1:0]  CONF_SEL_A,
  output logic [SEL_W-1:0]  CONF_SEL_B,
  output logic [DATA_W-1:0] CONST_A,
  output logic [DATA_W-1:0] CONST_B,
  output logic [AW-1:0]     CTX_IDX,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [DATA_W-1:0] const_a;
    logic [DATA_W-1:0] const_b;
    logic [RPT_W-1:0]  rpt;
  } ctx_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);

`ifdef ALU_SEL_CTX_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
  logic stop_in;
  assign stop_in = STOP;
`else
  localparam bit LOOP_EN = 1'b0;
  logic stop_in;
  assign stop_in = 1'b0;
`endif

  ctx_t ctx_mem [DEPTH];

  state_t            state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [AW-1:0]     last_reg, last_next;
  logic [RPT_W-1:0]  cnt_reg;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              wr_err_reg, wr_err_next;
  logic              stop_pend_reg, stop_pend_next;
  logic [SEL_W-1:0]  sel_a_reg, sel_b_reg;
  logic [DATA_W-1:0] const_a_reg, const_b_reg;
  logic              load, dec, wr_ok, stop_now;
  logic [AW-1:0]     last_start;

  // Oversized NUM_CTX requests are clamped to the full table.
  assign last_start = (NUM_CTX > DEPTH_V) ? AW'(DEPTH - 1) : AW'(NUM_CTX - ONE_V);

  // A START seen in IDLE takes priority over a simultaneous write.
  assign wr_ok       = WR_EN && (state_reg == IDLE) && !START;
  assign wr_err_next = WR_EN && !wr_ok;
  assign stop_now    = stop_pend_reg | stop_in;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    last_next      = last_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    stop_pend_next = stop_pend_reg;
    load           = 1'b0;
    dec            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (START) begin
          if (NUM_CTX == '0) begin
            done_next = 1'b1;
          end else begin
            state_next     = RUN;
            idx_next       = '0;
            last_next      = last_start;
            busy_next      = 1'b1;
            stop_pend_next = 1'b0;
            load           = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop_in) stop_pend_next = 1'b1;
        if (!STALL) begin
          if (cnt_reg == '0) begin
            if (stop_now || (!LOOP_EN && idx_reg == last_reg)) begin
              state_next     = IDLE;
              busy_next      = 1'b0;
              done_next      = 1'b1;
              stop_pend_next = 1'b0;
            end else begin
              load     = 1'b1;
              idx_next = (idx_reg == last_reg) ? '0 : idx_reg + AW'(1);
            end
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Table storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) ctx_mem[WR_ADDR] <= {WR_SEL_A, WR_SEL_B, WR_CONST_A, WR_CONST_B, WR_RPT};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      last_reg      <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wr_err_reg    <= 1'b0;
      stop_pend_reg <= 1'b0;
      sel_a_reg     <= '0;
      sel_b_reg     <= '0;
      const_a_reg   <= '0;
      const_b_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_reg      <= last_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      wr_err_reg    <= wr_err_next;
      stop_pend_reg <= stop_pend_next;
      if (load) begin
        sel_a_reg   <= ctx_mem[idx_next].sel_a;
        sel_b_reg   <= ctx_mem[idx_next].sel_b;
        const_a_reg <= ctx_mem[idx_next].const_a;
        const_b_reg <= ctx_mem[idx_next].const_b;
        cnt_reg     <= ctx_mem[idx_next].rpt;
      end else if (dec) begin
        cnt_reg <= cnt_reg - RPT_W'(1);
      end
    end
  end

  assign CONF_SEL_A = sel_a_reg;
  assign CONF_SEL_B = sel_b_reg;
  assign CONST_A    = const_a_reg;
  assign CONST_B    = const_b_reg;
  assign CTX_IDX    = idx_reg;
  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign WR_ERR     = wr_err_reg;

endmodule

// File: tb/tb_alu_sel_ctx_seq.sv
// Scoreboard bench for alu_sel_ctx_seq: runs are expanded from the table model into per-cycle
// expected records; a monitor pops one record whenever BUSY, DONE or WR_ERR is high.
module tb_alu_sel_ctx_seq;
  localparam int DEPTH = 8, AW = 3, SEL_W = 3, DATA_W = 16, RPT_W = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              WR_EN = 1'b0;
  logic [AW-1:0]     WR_ADDR = '0;
  logic [SEL_W-1:0]  WR_SEL_A = '0, WR_SEL_B = '0;
  logic [DATA_W-1:0] WR_CONST_A = '0, WR_CONST_B = '0;
  logic [RPT_W-1:0]  WR_RPT = '0;
  logic [AW:0]       NUM_CTX = '0;
  logic              START = 1'b0, STALL = 1'b0;
`ifdef ALU_SEL_CTX_LOOP_EN
  logic              STOP = 1'b0;
`endif
  logic              WR_ERR, BUSY, DONE;
  logic [SEL_W-1:0]  CONF_SEL_A, CONF_SEL_B;
  logic [DATA_W-1:0] CONST_A, CONST_B;
  logic [AW-1:0]     CTX_IDX;

  alu_sel_ctx_seq #(.DEPTH(DEPTH), .AW(AW), .SEL_W(SEL_W), .DATA_W(DATA_W), .RPT_W(RPT_W)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_SEL_A(WR_SEL_A),
    .WR_SEL_B(WR_SEL_B), .WR_CONST_A(WR_CONST_A), .WR_CONST_B(WR_CONST_B), .WR_RPT(WR_RPT),
    .WR_ERR(WR_ERR), .NUM_CTX(NUM_CTX), .START(START), .STALL(STALL),
`ifdef ALU_SEL_CTX_LOOP_EN
    .STOP(STOP),
`endif
    .CONF_SEL_A(CONF_SEL_A), .CONF_SEL_B(CONF_SEL_B), .CONST_A(CONST_A), .CONST_B(CONST_B),
    .CTX_IDX(CTX_IDX), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [SEL_W-1:0]  sa;
    logic [SEL_W-1:0]  sb;
    logic [DATA_W-1:0] ca;
    logic [DATA_W-1:0] cb;
    logic [AW-1:0]     idx;
    logic              busy;
    logic              done;
    logic              werr;
  } rec_t;

  int tests = 0;
  int failed = 0;
  rec_t sb_q[$];
  rec_t last_out = '0;

  logic [SEL_W-1:0]  tab_sa [DEPTH];
  logic [SEL_W-1:0]  tab_sb [DEPTH];
  logic [DATA_W-1:0] tab_ca [DEPTH];
  logic [DATA_W-1:0] tab_cb [DEPTH];
  int                tab_rpt[DEPTH];

  function automatic rec_t cur_out();
    rec_t r;
    r.sa = CONF_SEL_A; r.sb = CONF_SEL_B; r.ca = CONST_A; r.cb = CONST_B;
    r.idx = CTX_IDX; r.busy = BUSY; r.done = DONE; r.werr = WR_ERR;
    return r;
  endfunction

  function automatic rec_t mk(input int k);
    rec_t r;
    r.sa = tab_sa[k]; r.sb = tab_sb[k]; r.ca = tab_ca[k]; r.cb = tab_cb[k];
    r.idx = AW'(k); r.busy = 1'b1; r.done = 1'b0; r.werr = 1'b0;
    return r;
  endfunction

  task automatic show_fail(input string name, input rec_t a, input rec_t e);
    $display("FAIL %s: got sa=%0d sb=%0d ca=%h cb=%h idx=%0d busy=%0b done=%0b werr=%0b, expected sa=%0d sb=%0d ca=%h cb=%h idx=%0d busy=%0b done=%0b werr=%0b",
             name, a.sa, a.sb, a.ca, a.cb, a.idx, a.busy, a.done, a.werr,
             e.sa, e.sb, e.ca, e.cb, e.idx, e.busy, e.done, e.werr);
  endtask

  // Monitor: every cycle with activity must match the next queued expectation.
  initial begin
    rec_t a, e;
    int n;
    n = 0;
    forever begin
      @(negedge CLK);
      if (BUSY === 1'b1 || DONE === 1'b1 || WR_ERR === 1'b1) begin
        a = cur_out();
        tests++;
        if (sb_q.size() == 0) begin
          failed++;
          show_fail("unexpected_output", a, '0);
        end else begin
          e = sb_q.pop_front();
          if (a !== e) begin
            failed++;
            show_fail($sformatf("record%0d", n), a, e);
          end
        end
        n++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input int sa, input int sbv, input int ca, input int cb, input int rpt);
    WR_EN = 1'b1; WR_ADDR = AW'(a); WR_SEL_A = SEL_W'(sa); WR_SEL_B = SEL_W'(sbv);
    WR_CONST_A = DATA_W'(ca); WR_CONST_B = DATA_W'(cb); WR_RPT = RPT_W'(rpt);
    tick();
    WR_EN = 1'b0;
    tab_sa[a] = SEL_W'(sa); tab_sb[a] = SEL_W'(sbv);
    tab_ca[a] = DATA_W'(ca); tab_cb[a] = DATA_W'(cb); tab_rpt[a] = rpt;
  endtask

  task automatic junk_write();
    WR_EN = 1'b1; WR_ADDR = AW'($urandom_range(0, DEPTH-1)); WR_SEL_A = SEL_W'($urandom);
    WR_SEL_B = SEL_W'($urandom); WR_CONST_A = DATA_W'($urandom); WR_CONST_B = DATA_W'($urandom);
    WR_RPT = RPT_W'($urandom);
  endtask

  task automatic check_now(input string name, input rec_t e);
    rec_t a;
    a = cur_out();
    tests++;
    if (a !== e) begin
      failed++;
      show_fail(name, a, e);
    end
  endtask

  // wr_at: cycle of a (rejected) write, -1 = START cycle, -2 = none. rst_at: -1 = none.
  task automatic run_prog(input int num, input int stall_at, input int stall_len,
                          input int wr_at, input int rst_at);
    rec_t lst[$];
    rec_t d;
    int n, ncyc;
    n = (num > DEPTH) ? DEPTH : num;
    if (n == 0) begin
      d = last_out; d.busy = 1'b0; d.done = 1'b1; d.werr = 1'b0;
      lst.push_back(d);
    end else begin
      for (int k = 0; k < n; k++)
        for (int r = 0; r <= tab_rpt[k]; r++) lst.push_back(mk(k));
      for (int s = 0; s < stall_len; s++) lst.insert(stall_at + 1, lst[stall_at]);
      d = lst[lst.size()-1]; d.done = 1'b1; d.busy = 1'b0;
      lst.push_back(d);
      if (wr_at >= -1 && wr_at + 1 < lst.size()) lst[wr_at+1].werr = 1'b1;
    end
    ncyc = (rst_at >= 0) ? rst_at + 1 : lst.size() - 1;
    if (rst_at >= 0) begin
      while (lst.size() > rst_at + 1) void'(lst.pop_back());
      last_out = '0;
    end else if (n > 0) begin
      last_out = lst[lst.size()-1]; last_out.done = 1'b0;
    end
    foreach (lst[i]) sb_q.push_back(lst[i]);

    NUM_CTX = (AW+1)'(num);
    START = 1'b1;
    if (wr_at == -1 && n > 0) junk_write();
    tick();
    START = 1'b0; WR_EN = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      STALL = (c >= stall_at && c < stall_at + stall_len);
      if (c == wr_at) junk_write(); else WR_EN = 1'b0;
      RST = (c == rst_at);
`ifdef ALU_SEL_CTX_LOOP_EN
      STOP = (lst[c].idx == AW'(n - 1));
`endif
      tick();
    end
    STALL = 1'b0; WR_EN = 1'b0;
`ifdef ALU_SEL_CTX_LOOP_EN
    STOP = 1'b0;
`endif
    if (rst_at >= 0) begin
      check_now("reset_mid_run", '0);
      RST = 1'b0;
    end
    tick(); tick();
    tests++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected records left unconsumed, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic load_plan();
    wr(0, 0, 1, 'h0011, 'h0022, 0);
    wr(1, 6, 7, 'h1234, 'hABCD, 2);
    wr(2, 3, 5, 'hFFFF, 'h0001, 1);
  endtask

  initial begin
    int num, st, sl, wa, nb;
    for (int i = 0; i < DEPTH; i++) begin
      tab_sa[i] = '0; tab_sb[i] = '0; tab_ca[i] = '0; tab_cb[i] = '0; tab_rpt[i] = 0;
    end
    RST = 1'b1;
    tick(); tick();
    check_now("reset_state", '0);
    RST = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(i, 0, 0, 0, 0, 0);

    load_plan();
    run_prog(3, 0, 0, -2, -1);   // basic program
    run_prog(3, 2, 4, -2, -1);   // stall inside entry1
    run_prog(3, 0, 0, 2, -1);    // write while busy
    run_prog(3, 0, 0, -2, -1);   // rerun shows original entry1
    run_prog(3, 0, 0, -1, -1);   // write with START
    run_prog(0, 0, 0, -2, -1);   // empty sequence

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom, $urandom, $urandom, $urandom, 15);
    run_prog(8, 0, 0, -2, -1);   // full table, all RPT=15
    run_prog(12, 5, 2, 40, -1);  // clamped NUM_CTX

    load_plan();
    run_prog(3, 0, 0, -2, 1);    // reset during entry1
    run_prog(3, 0, 0, -2, -1);   // replay from entry0

    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 3; j++)
        wr($urandom_range(0, DEPTH-1), $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
      num = $urandom_range(0, 15);
      nb = 0;
      for (int k = 0; k < ((num > DEPTH) ? DEPTH : num); k++) nb += tab_rpt[k] + 1;
      st = (nb > 0) ? $urandom_range(0, nb - 1) : 0;
      sl = (nb > 0) ? $urandom_range(0, 3) : 0;
      wa = (nb > 0) ? $urandom_range(0, nb + sl) - 2 : -2;
      run_prog(num, st, sl, wa, -1);
    end

`ifdef ALU_SEL_CTX_LOOP_EN
    begin
      rec_t ra, rb, d;
      wr(0, 2, 3, 'hAAAA, 'h5555, 0);
      wr(1, 4, 6, 'hBEEF, 'hCAFE, 1);
      ra = mk(0); rb = mk(1);
      for (int p = 0; p < 3; p++) begin
        sb_q.push_back(ra); sb_q.push_back(rb); sb_q.push_back(rb);
      end
      d = rb; d.busy = 1'b0; d.done = 1'b1;
      sb_q.push_back(d);
      last_out = rb;
      NUM_CTX = (AW+1)'(2);
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int c = 0; c < 9; c++) begin
        STOP = (c == 7);
        tick();
      end
      STOP = 1'b0;
      tick(); tick();
      tests++;
      if (sb_q.size() != 0) begin
        failed++;
        $display("FAIL loop_drain: %0d expected records left unconsumed, required 0", sb_q.size());
        sb_q.delete();
      end
    end
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
